apb_mem_slave_ws: RTL and testbench
===================================

// Module: apb_mem_slave_ws
// PURPOSE
//  APB4 memory-mapped slave, the parametrised successor of the basic APB RAM slave.
//  Adds configurable wait states, byte-addressed word alignment, and a DEPTH independent of address width.
//  Adds PSLVERR on bad accesses and a privileged-write lock region qualified by PPROT[0].
//  Sits on the APB bridge decode fabric as a generic scratch/config RAM target.
// PARAMETERS
//  ADDR_WIDTH   12   PADDR width, byte address
//  DATA_WIDTH   32   PWDATA/PRDATA width; multiple of 8, max 64
//  DEPTH        64   number of DATA_WIDTH words implemented
//  WAIT_CYCLES  2    wait states inserted per access (0..15); 0 = no-wait APB
//  LOCK_WORDS   4    words [0..LOCK_WORDS-1] writable only when PPROT[0]=1
// PORTS
//  PCLK      in   1              APB clock, all logic rising-edge
//  PRESET    in   1              asynchronous active-high reset
//  PSEL      in   1              slave select
//  PENABLE   in   1              access phase
//  PWRITE    in   1              1=write, 0=read
//  PADDR     in   ADDR_WIDTH     byte address
//  PPROT     in   3              protection; only bit0 (privileged) used
//  PSTRB     in   DATA_WIDTH/8   write byte strobes
//  PWDATA    in   DATA_WIDTH     write data
//  PREADY    out  1              transfer complete
//  PRDATA    out  DATA_WIDTH     read data, valid only when PREADY=1 and read without error
//  PSLVERR   out  1              error, valid only when PREADY=1
//  err_cnt   out  8              saturating count of errored transfers
// BEHAVIOUR
//  - Reset (async, PRESET=1): state=IDLE, wait counter=0, err_cnt=0, PREADY=0, PSLVERR=0, PRDATA=0.
//    Memory array is NOT reset; contents survive reset.
//  - idx = PADDR >> log2(DATA_WIDTH/8); off = low log2(DATA_WIDTH/8) bits of PADDR.
//  - err = (off!=0) | (idx>=DEPTH) | (PWRITE & idx<LOCK_WORDS & !PPROT[0]).
//  - FSM IDLE -> ACCESS on PSEL & !PENABLE (setup edge); load cnt=WAIT_CYCLES.
//  - ACCESS, PSEL=1, cnt!=0: PREADY=0, cnt--.
//  - ACCESS, PSEL=1, cnt==0: PREADY=1 (decoded from registered state/cnt; no input-to-PREADY path).
//    Next state IDLE. Back-to-back setup is accepted on the following cycle.
//  - Latency: transfer = 1 setup + (WAIT_CYCLES+1) access cycles.
//  - Write commit: at the PCLK edge where PREADY=1 & PWRITE & !err.
//    Only bytes with PSTRB[i]=1 are updated. PSTRB=0 is a legal no-op.
//  - Read: PRDATA=mem[idx] while PREADY=1 & !PWRITE & !err; otherwise PRDATA=0.
//  - PSLVERR = PREADY & err. On error the memory is untouched, PRDATA=0, and err_cnt increments (saturates at 255).
//  - Address/control are sampled each ACCESS cycle; APB4 requires they stay stable.
//    The design does not latch them.
//  - PSEL deasserted in ACCESS (protocol abort): return to IDLE next edge, no write, no err_cnt change.
//  - PENABLE=1 while IDLE: ignored; no transfer starts.
//  - PRESET asserted mid-transfer: FSM to IDLE immediately, pending write dropped, PREADY=0 the same cycle.
// STRUCTURE
//  - apb_pkg: state enum {IDLE,ACCESS}, PPROT_PRIV_BIT=0, clog2 helper, ERR_CNT_W=8.
//  - Sub-module apb_bytemem: DEPTH x DATA_WIDTH register array.
//    Interface: byte-enable write port, asynchronous read port.
//  - Top level holds the FSM, wait counter, error decode and err_cnt.
// TESTING (defaults unless stated)
//  - Write 0xDEADBEEF @0x040, PPROT=0, PSTRB=F; then read @0x040.
//    Each transfer has PREADY low 2 cycles; read returns 0xDEADBEEF, PSLVERR=0.
//  - Write 0x11223344 @0x044, PSTRB=0101; then write 0xAABBCCDD @0x044, PSTRB=1010.
//    Read @0x044 -> 0xAA22CC44.
//  - Read @0x100 (idx 64) and write @0x042 (misaligned).
//    Both PSLVERR=1 with PREADY; PRDATA=0; mem unchanged; err_cnt=2.
//  - Write 0x5 @0x004 with PPROT=0 -> PSLVERR=1, read-back is the old value.
//    Same write with PPROT=1 -> PSLVERR=0, read-back is 0x5.
//  - Assert PRESET in the 2nd wait cycle of a write @0x048 -> PREADY=0, location unchanged, err_cnt=0.
//    Then the next read completes normally.
//  - WAIT_CYCLES=0 build: 4 back-to-back writes then reads -> PREADY in every access cycle, data matches.
//    Also drop PSEL mid-access -> no commit.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 wait-state memory slave.
// Imported by the top level and the byte-enable memory.
package apb_pkg;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   localparam int PPROT_PRIV_BIT = 0;
   localparam int ERR_CNT_W      = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/apb_bytemem.sv
// DEPTH x DATA_WIDTH register array with a byte-enable write port
// and an asynchronous read port. Contents are never reset.
module apb_bytemem
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int AW         = 6
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [AW-1:0]           addr,
   input  logic [DATA_WIDTH/8-1:0] strb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 scratch/config RAM slave with programmable wait states,
// PSLVERR on bad accesses and a privileged-write lock region.
module apb_mem_slave_ws
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int LOCK_WORDS  = 4
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [2:0]              PPROT,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = clog2(BYTES);
   localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

   state_t                state;
   logic [3:0]            cnt;
   logic                  rdy;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  bad_off;
   logic                  bad_idx;
   logic                  locked;
   logic                  err;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;

   // Only the privileged bit of PPROT takes part in the decode.
   logic unused_prot;
   assign unused_prot = ^PPROT[2:1];

   assign idx     = PADDR >> OFF_W;
   assign bad_off = (PADDR & OFF_MASK) != '0;
   assign bad_idx = idx >= ADDR_WIDTH'(DEPTH);
   assign locked  = PWRITE & (idx < ADDR_WIDTH'(LOCK_WORDS))
                  & ~PPROT[PPROT_PRIV_BIT];
   assign err     = bad_off | bad_idx | locked;
   assign we      = rdy & PSEL & PWRITE & ~err;

   assign PREADY  = rdy;
   assign PSLVERR = rdy & err;
   assign PRDATA  = (rdy & ~PWRITE & ~err) ? rdata : '0;

   // rdy mirrors (state==ACCESS && cnt==0) but comes straight from a flop.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= IDLE;
         cnt     <= '0;
         rdy     <= 1'b0;
         err_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  state <= ACCESS;
                  cnt   <= 4'(WAIT_CYCLES);
                  rdy   <= (WAIT_CYCLES == 0);
               end
            end
            ACCESS: begin
               if (!PSEL) begin
                  state <= IDLE;
                  rdy   <= 1'b0;
               end else if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
                  rdy <= (cnt == 4'd1);
               end else begin
                  state <= IDLE;
                  rdy   <= 1'b0;
                  if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               rdy   <= 1'b0;
            end
         endcase
      end
   end

   apb_bytemem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (IDX_W)
   ) u_mem (
      .clk   (PCLK),
      .we    (we),
      .addr  (idx[IDX_W-1:0]),
      .strb  (PSTRB),
      .wdata (PWDATA),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Bench for apb_mem_slave_ws: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance, directed vectors, corner sequences and a random run.
module tb_apb_mem_slave_ws;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [2];
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [11:0] paddr   [2];
   logic [2:0]  pprot   [2];
   logic [3:0]  pstrb   [2];
   logic [31:0] pwdata  [2];
   logic        pready  [2];
   logic [31:0] prdata  [2];
   logic        pslverr [2];
   logic [7:0]  err_cnt [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [2][64];
   int          m_ecnt [2];
   int          wc [2] = '{2, 0};

   apb_mem_slave_ws u_ws2 (
      .PCLK    (clk),
      .PRESET  (rst[0]),
      .PSEL    (psel[0]),
      .PENABLE (penable[0]),
      .PWRITE  (pwrite[0]),
      .PADDR   (paddr[0]),
      .PPROT   (pprot[0]),
      .PSTRB   (pstrb[0]),
      .PWDATA  (pwdata[0]),
      .PREADY  (pready[0]),
      .PRDATA  (prdata[0]),
      .PSLVERR (pslverr[0]),
      .err_cnt (err_cnt[0])
   );

   apb_mem_slave_ws #(.WAIT_CYCLES(0)) u_ws0 (
      .PCLK    (clk),
      .PRESET  (rst[1]),
      .PSEL    (psel[1]),
      .PENABLE (penable[1]),
      .PWRITE  (pwrite[1]),
      .PADDR   (paddr[1]),
      .PPROT   (pprot[1]),
      .PSTRB   (pstrb[1]),
      .PWDATA  (pwdata[1]),
      .PREADY  (pready[1]),
      .PRDATA  (prdata[1]),
      .PSLVERR (pslverr[1]),
      .err_cnt (err_cnt[1])
   );

   typedef struct {
      bit          wr;
      logic [11:0] a;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [2:0]  pr;
      logic [31:0] erd;
      bit          eerr;
      int          ecnt;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: word-array memory and transfer outcome from address arithmetic.
   function automatic void model(input int d, input bit wr,
                                 input logic [11:0] a, input logic [31:0] wd,
                                 input logic [3:0] st, input logic [2:0] pr,
                                 output logic [31:0] erd, output bit eerr);
      int idx;
      idx  = int'(a) / 4;
      eerr = (int'(a) % 4 != 0) || (idx >= 64) || (wr && idx < 4 && !pr[0]);
      erd  = 32'h0;
      if (eerr) begin
         if (m_ecnt[d] < 255) m_ecnt[d]++;
      end else if (wr) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) m_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         erd = m_mem[d][idx];
      end
   endfunction

   // Called just after a falling edge; returns just after a falling edge.
   task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] pr, output logic [31:0] rd,
                       output logic er, output int waits);
      psel[d] = 1'b1;
      penable[d] = 1'b0;
      pwrite[d] = wr;
      paddr[d] = a;
      pwdata[d] = wd;
      pstrb[d] = st;
      pprot[d] = pr;
      @(negedge clk);
      penable[d] = 1'b1;
      waits = 0;
      while (pready[d] !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      rd = prdata[d];
      er = pslverr[d];
      @(negedge clk);
      psel[d] = 1'b0;
      penable[d] = 1'b0;
   endtask

   task automatic xfer_chk(input int d, input bit wr, input logic [11:0] a,
                           input logic [31:0] wd, input logic [3:0] st,
                           input logic [2:0] pr, input string nm);
      logic [31:0] erd;
      logic [31:0] rd;
      bit          eerr;
      logic        er;
      int          w;
      model(d, wr, a, wd, st, pr, erd, eerr);
      xfer(d, wr, a, wd, st, pr, rd, er, w);
      chk({nm, " rdata"}, rd, erd);
      chk({nm, " pslverr"}, er, eerr);
      chk({nm, " waits"}, w, wc[d]);
      chk({nm, " err_cnt"}, err_cnt[d], m_ecnt[d]);
   endtask

   initial begin
      logic [31:0] drd;
      logic [31:0] rd;
      bit          derr;
      logic        er;
      int          w;
      int          r;
      logic [11:0] a;

      vt[0]  = '{1, 12'h040, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 0, 0};
      vt[1]  = '{0, 12'h040, 32'h0, 4'hF, 3'd0, 32'hDEADBEEF, 0, 0};
      vt[2]  = '{1, 12'h044, 32'h11223344, 4'b0101, 3'd0, 32'h0, 0, 0};
      vt[3]  = '{1, 12'h044, 32'hAABBCCDD, 4'b1010, 3'd0, 32'h0, 0, 0};
      vt[4]  = '{0, 12'h044, 32'h0, 4'hF, 3'd0, 32'hAA22CC44, 0, 0};
      vt[5]  = '{0, 12'h100, 32'h0, 4'hF, 3'd0, 32'h0, 1, 1};
      vt[6]  = '{1, 12'h042, 32'h12121212, 4'hF, 3'd0, 32'h0, 1, 2};
      vt[7]  = '{0, 12'h040, 32'h0, 4'hF, 3'd0, 32'hDEADBEEF, 0, 2};
      vt[8]  = '{1, 12'h004, 32'h77, 4'hF, 3'd1, 32'h0, 0, 2};
      vt[9]  = '{1, 12'h004, 32'h5, 4'hF, 3'd0, 32'h0, 1, 3};
      vt[10] = '{0, 12'h004, 32'h0, 4'hF, 3'd0, 32'h77, 0, 3};
      vt[11] = '{1, 12'h004, 32'h5, 4'hF, 3'd1, 32'h0, 0, 3};
      vt[12] = '{0, 12'h004, 32'h0, 4'hF, 3'd0, 32'h5, 0, 3};

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         psel[d] = 1'b0;
         penable[d] = 1'b0;
         pwrite[d] = 1'b0;
         paddr[d] = '0;
         pprot[d] = '0;
         pstrb[d] = '0;
         pwdata[d] = '0;
         m_ecnt[d] = 0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset pready", pready[d], 1'b0);
         chk("reset pslverr", pslverr[d], 1'b0);
         chk("reset prdata", prdata[d], 32'h0);
         chk("reset err_cnt", err_cnt[d], 8'h0);
         rst[d] = 1'b0;
      end
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         model(0, vt[i].wr, vt[i].a, vt[i].wd, vt[i].st, vt[i].pr, drd, derr);
         xfer(0, vt[i].wr, vt[i].a, vt[i].wd, vt[i].st, vt[i].pr, rd, er, w);
         chk($sformatf("vec%0d rdata", i), rd, vt[i].erd);
         chk($sformatf("vec%0d pslverr", i), er, vt[i].eerr);
         chk($sformatf("vec%0d waits", i), w, 2);
         chk($sformatf("vec%0d err_cnt", i), err_cnt[0], vt[i].ecnt);
      end

      // PENABLE without a setup phase must not start a transfer.
      psel[0] = 1'b1;
      penable[0] = 1'b1;
      pwrite[0] = 1'b1;
      paddr[0] = 12'h040;
      pwdata[0] = 32'h0;
      pstrb[0] = 4'hF;
      pprot[0] = 3'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle penable pready", pready[0], 1'b0);
      end
      psel[0] = 1'b0;
      penable[0] = 1'b0;
      @(negedge clk);
      xfer_chk(0, 0, 12'h040, 32'h0, 4'hF, 3'd0, "idle penable readback");

      // Reset in the second wait cycle of a write.
      xfer_chk(0, 1, 12'h048, 32'h12345678, 4'hF, 3'd0, "pre-reset write");
      psel[0] = 1'b1;
      penable[0] = 1'b0;
      pwrite[0] = 1'b1;
      paddr[0] = 12'h048;
      pwdata[0] = 32'hCAFEF00D;
      pstrb[0] = 4'hF;
      pprot[0] = 3'd1;
      @(negedge clk);
      penable[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b1;
      #1;
      chk("mid reset pready", pready[0], 1'b0);
      chk("mid reset err_cnt", err_cnt[0], 8'h0);
      @(negedge clk);
      rst[0] = 1'b0;
      psel[0] = 1'b0;
      penable[0] = 1'b0;
      m_ecnt[0] = 0;
      @(negedge clk);
      xfer_chk(0, 0, 12'h048, 32'h0, 4'hF, 3'd0, "post reset read");

      // Abort in the ready cycle of a wait-state write.
      psel[0] = 1'b1;
      penable[0] = 1'b0;
      pwrite[0] = 1'b1;
      paddr[0] = 12'h048;
      pwdata[0] = 32'hFFFFFFFF;
      pstrb[0] = 4'hF;
      @(negedge clk);
      penable[0] = 1'b1;
      repeat (2) @(negedge clk);
      psel[0] = 1'b0;
      penable[0] = 1'b0;
      @(negedge clk);
      xfer_chk(0, 0, 12'h048, 32'h0, 4'hF, 3'd0, "abort2 readback");

      // No-wait instance: back-to-back writes then reads.
      for (int i = 0; i < 4; i++)
         xfer_chk(1, 1, 12'(16 + 4 * i), 32'hA0000000 + i, 4'hF, 3'd0,
                  $sformatf("nw write%0d", i));
      for (int i = 0; i < 4; i++)
         xfer_chk(1, 0, 12'(16 + 4 * i), 32'h0, 4'hF, 3'd0,
                  $sformatf("nw read%0d", i));

      // No-wait abort: PSEL dropped in the access cycle.
      psel[1] = 1'b1;
      penable[1] = 1'b0;
      pwrite[1] = 1'b1;
      paddr[1] = 12'h010;
      pwdata[1] = 32'hFFFFFFFF;
      pstrb[1] = 4'hF;
      pprot[1] = 3'd1;
      @(negedge clk);
      psel[1] = 1'b0;
      penable[1] = 1'b0;
      @(negedge clk);
      xfer_chk(1, 0, 12'h010, 32'h0, 4'hF, 3'd0, "nw abort readback");

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 64; i++)
            xfer_chk(d, 1, 12'(4 * i), $urandom, 4'hF, 3'd1, "preload");
         for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = 12'(4 * $urandom_range(0, 63));
            else if (r == 7) a = 12'(4 * $urandom_range(64, 1023));
            else a = 12'($urandom_range(0, 4095));
            xfer_chk(d, 1'($urandom_range(0, 1)), a, $urandom,
                     4'($urandom), 3'($urandom), $sformatf("rand%0d", n));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
